// File: rtl/line_win_pkg.sv
// Shared types and constants for the 3x3 window sequencing controller.
package line_win_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        WAIT_DE,
        ACTIVE
    } state_t;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = ERR_CNT_W'(255);

endpackage

// File: rtl/line_win_ctrl_if.sv
// Video input and line-FIFO / window control bundle.
// master: the controller side; slave: video source plus FIFO/window consumer.
interface line_win_ctrl_if;
    logic video_vs;
    logic video_de;
    logic fifo_rst;
    logic wr1_en;
    logic wr2_en;
    logic rd_en;
    logic win_de;
    logic win_row_inv;
    logic win_col_inv;

    modport master (
        input  video_vs, video_de,
        output fifo_rst, wr1_en, wr2_en, rd_en, win_de, win_row_inv, win_col_inv
    );

    modport slave (
        output video_vs, video_de,
        input  fifo_rst, wr1_en, wr2_en, rd_en, win_de, win_row_inv, win_col_inv
    );
endinterface

// File: rtl/sig_delay.sv
// Fixed-depth register pipe, reset to zero; used to align de/x/y with the window.
module sig_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             video_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    // shift d through DEPTH stages
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];
endmodule

// File: rtl/line_win_ctrl.sv
// Sequencing controller for the 1-bit 3x3 window generator: frame/line
// position tracking, line-FIFO flush and enables, window-valid with border
// flags, and malformed-frame detection.
// Optional: define LINE_WIN_ERR_CNT_EN to build the saturating err_cnt counter;
// otherwise err_cnt is tied to 0.
module line_win_ctrl
    import line_win_pkg::*;
#(
    parameter int IMG_WIDTH    = 1920,
    parameter int IMG_HEIGHT   = 1080,
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_W        = 12
) (
    input  logic                 video_clk,
    input  logic                 rst_n,
    input  logic                 err_clr,
    line_win_ctrl_if.master      vif,
    output logic [CNT_W-1:0]     x_cnt,
    output logic [CNT_W-1:0]     y_cnt,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 line_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] BORDER  = CNT_W'(2);

    state_t           state;
    logic [FC_W-1:0]  flush_cnt;
    logic             vs_d, de_d;
    logic             vs_rise, cnt_phase, en_de, line_last, frame_last;
    logic             short_line, err_ev;
    logic             win_de_d2;
    logic [CNT_W-1:0] x_d2, y_d2;

    assign vs_rise    = vif.video_vs & ~vs_d;
    assign cnt_phase  = (state == WAIT_DE) || (state == ACTIVE);
    assign en_de      = vif.video_de & cnt_phase;
    assign line_last  = (x_cnt == X_LAST);
    assign frame_last = en_de & line_last & (y_cnt == Y_LAST);
    // A line that ends early still advances y so both FIFOs stay on the same line phase
    assign short_line = cnt_phase & ~vif.video_de & de_d & (x_cnt != '0);
    assign err_ev     = (vs_rise & (state == ACTIVE))
                      | (vif.video_de & (state == FLUSH))
                      | short_line;

    assign busy         = (state != IDLE);
    assign vif.fifo_rst = (state == FLUSH);
    assign vif.wr1_en   = en_de & (y_cnt < Y_LAST);
    assign vif.rd_en    = en_de & (y_cnt != '0);

    // edge-detect history for vs and de
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b0;
            de_d <= 1'b0;
        end else begin
            vs_d <= vif.video_vs;
            de_d <= vif.video_de;
        end
    end

    // frame sequencer: flush on every frame start, then count pixels to frame end
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            flush_cnt  <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (vs_rise) begin
                state     <= FLUSH;
                flush_cnt <= '0;
                x_cnt     <= '0;
                y_cnt     <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    FLUSH: begin
                        if (flush_cnt == FC_LAST) state <= WAIT_DE;
                        else flush_cnt <= flush_cnt + FC_W'(1);
                    end
                    default: begin
                        if (en_de) begin
                            state <= ACTIVE;
                            if (frame_last) begin
                                state      <= IDLE;
                                x_cnt      <= '0;
                                y_cnt      <= '0;
                                frame_done <= 1'b1;
                            end else if (line_last) begin
                                x_cnt <= '0;
                                y_cnt <= y_cnt + CNT_W'(1);
                            end else begin
                                x_cnt <= x_cnt + CNT_W'(1);
                            end
                        end else if (short_line) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // FIFO 2 is written with FIFO 1's output, which appears one cycle after the read
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) vif.wr2_en <= 1'b0;
        else        vif.wr2_en <= vif.wr1_en;
    end

    sig_delay #(
        .WIDTH (1 + 2*CNT_W),
        .DEPTH (2)
    ) u_win_dly (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .d         ({en_de, x_cnt, y_cnt}),
        .q         ({win_de_d2, x_d2, y_d2})
    );

    assign vif.win_de      = win_de_d2;
    assign vif.win_col_inv = win_de_d2 & (x_d2 < BORDER);
    assign vif.win_row_inv = win_de_d2 & (y_d2 < BORDER);

    // sticky error flag; a new event beats a simultaneous clear
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n)       line_err <= 1'b0;
        else if (err_ev)  line_err <= 1'b1;
        else if (err_clr) line_err <= 1'b0;
    end

`ifdef LINE_WIN_ERR_CNT_EN
    // saturating error event counter; clear with a coincident event leaves 1
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= ERR_CNT_W'(err_ev);
        else if (err_ev && (err_cnt != ERR_CNT_MAX))
            err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_line_win_ctrl.sv
// Directed bench for line_win_ctrl at IMG_WIDTH=8, IMG_HEIGHT=4, FLUSH_CYCLES=4.
module tb_line_win_ctrl;
    import line_win_pkg::*;

    localparam int W = 8, H = 4, FC = 4, CW = 4;
`ifdef LINE_WIN_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                 video_clk = 1'b0;
    logic                 rst_n;
    logic                 err_clr;
    logic [CW-1:0]        x_cnt, y_cnt;
    logic                 frame_done, busy, line_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    line_win_ctrl_if vif ();

    line_win_ctrl #(
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .video_clk  (video_clk),
        .rst_n      (rst_n),
        .err_clr    (err_clr),
        .vif        (vif),
        .x_cnt      (x_cnt),
        .y_cnt      (y_cnt),
        .frame_done (frame_done),
        .busy       (busy),
        .line_err   (line_err),
        .err_cnt    (err_cnt)
    );

    always #5 video_clk = ~video_clk;

    int n_tests = 0, n_fail = 0;
    int cyc, n_fr, n_wr1, n_wr2, n_rd, n_wd, n_row, n_col, n_fd, wr2_bad;
    int first_de, last_de, first_wd, last_wd, fd_cyc, row_last;
    logic prev_wr1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        n_fr = 0; n_wr1 = 0; n_wr2 = 0; n_rd = 0; n_wd = 0; n_row = 0; n_col = 0;
        n_fd = 0; wr2_bad = 0; first_de = -1; last_de = -1; first_wd = -1;
        last_wd = -1; fd_cyc = -1; row_last = -1; prev_wr1 = 1'b0;
    endtask

    // one clock: sample the settled cycle mid-period, then advance past the edge
    task automatic step();
        #2;
        n_fr  += int'(vif.fifo_rst);
        n_wr1 += int'(vif.wr1_en);
        n_wr2 += int'(vif.wr2_en);
        n_rd  += int'(vif.rd_en);
        if (vif.wr2_en !== prev_wr1) wr2_bad++;
        prev_wr1 = vif.wr1_en;
        if (vif.video_de && busy && !vif.fifo_rst) begin
            if (first_de < 0) first_de = cyc;
            last_de = cyc;
        end
        if (vif.win_de) begin
            if (first_wd < 0) first_wd = cyc;
            last_wd = cyc;
            if (vif.win_row_inv) begin n_row++; row_last = n_wd; end
            if (vif.win_col_inv) n_col++;
            n_wd++;
        end
        if (frame_done) begin n_fd++; fd_cyc = cyc; end
        cyc++;
        @(posedge video_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic line(input int n);
        vif.video_de = 1'b1;
        for (int i = 0; i < n; i++) step();
        vif.video_de = 1'b0;
    endtask

    // four full lines, two idle cycles between lines, none after the last
    task automatic full_frame();
        for (int l = 0; l < H; l++) begin
            line(W);
            if (l < H-1) idle(2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0;
        clr_counts();
        rst_n = 1'b0; err_clr = 1'b0; vif.video_vs = 1'b0; vif.video_de = 1'b0;
        repeat (2) @(posedge video_clk);
        #1;
        chk("reset_outputs", {x_cnt, y_cnt, frame_done, busy, line_err, err_cnt,
            vif.fifo_rst, vif.wr1_en, vif.wr2_en, vif.rd_en, vif.win_de,
            vif.win_row_inv, vif.win_col_inv}, 0);
        rst_n = 1'b1;
        step();

        // reset asserted mid-line in ACTIVE
        vif.video_vs = 1'b1; step(); vif.video_vs = 1'b0;
        idle(FC);
        vif.video_de = 1'b1;
        idle(3);
        chk("pre_reset_x", x_cnt, 3);
        rst_n = 1'b0;
        #2;
        chk("midreset_cnt", {x_cnt, y_cnt}, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_en", {vif.wr1_en, vif.rd_en, vif.wr2_en, vif.win_de}, 0);
        @(posedge video_clk); #1;
        vif.video_de = 1'b0;
        rst_n = 1'b1;
        step();

        // frame 1: clean full frame
        clr_counts();
        vif.video_vs = 1'b1; step(); vif.video_vs = 1'b0;
        idle(FC);
        full_frame();
        idle(3);
        chk("f1_fifo_rst_cycles", n_fr, 4);
        chk("f1_wr1_count", n_wr1, 24);
        chk("f1_rd_count", n_rd, 24);
        chk("f1_wr2_count", n_wr2, 24);
        chk("f1_wr2_is_wr1_d1", wr2_bad, 0);
        chk("f1_win_de_count", n_wd, 32);
        chk("f1_win_de_latency", first_wd - first_de, 2);
        chk("f1_last_win_de_lat", last_wd - last_de, 2);
        chk("f1_frame_done_count", n_fd, 1);
        chk("f1_frame_done_pos", fd_cyc - last_de, 1);
        chk("f1_row_inv_count", n_row, 16);
        chk("f1_row_inv_last_idx", row_last, 15);
        chk("f1_col_inv_count", n_col, 8);
        chk("f1_idle_after", {busy, x_cnt, y_cnt}, 0);
        chk("f1_no_err", line_err, 0);

        // frame 2: vs_rise lands in the frame_done cycle
        clr_counts();
        vif.video_vs = 1'b1; step(); vif.video_vs = 1'b0;
        idle(FC);
        full_frame();
        vif.video_vs = 1'b1; step(); vif.video_vs = 1'b0;
        chk("f2_frame_done_count", n_fd, 1);
        chk("f2_frame_done_pos", fd_cyc - last_de, 1);
        clr_counts();
        step();
        chk("f2_vs_no_err", line_err, 0);
        chk("f2_busy_flush", {busy, vif.fifo_rst}, 2'b11);
        idle(FC-1);
        chk("f3_flush_cycles", n_fr, 4);

        // frame 3: second line cut short at 5 pixels
        line(W);
        chk("f3_y_after_line0", y_cnt, 1);
        line(5);
        step();
        chk("short_line_err", line_err, 1);
        chk("short_line_xy", {x_cnt, y_cnt}, {4'd0, 4'd2});
        chk("short_line_err_cnt", err_cnt, CNT_EN ? 1 : 0);

        // truncated frame and de during flush
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("clr_line_err", line_err, 0);
        chk("clr_err_cnt", err_cnt, 0);
        vif.video_vs = 1'b1; step(); vif.video_vs = 1'b0;
        chk("trunc_err", line_err, 1);
        chk("trunc_flush_xy", {vif.fifo_rst, x_cnt, y_cnt}, {1'b1, 8'd0});
        chk("trunc_err_cnt", err_cnt, CNT_EN ? 1 : 0);
        vif.video_de = 1'b1; step(); vif.video_de = 1'b0;
        chk("flush_de_err_cnt", err_cnt, CNT_EN ? 2 : 0);
        chk("flush_de_no_win", {vif.wr1_en, vif.rd_en}, 0);

        // clear coinciding with an error event
        err_clr = 1'b1; vif.video_de = 1'b1; step();
        err_clr = 1'b0; vif.video_de = 1'b0;
        chk("clr_vs_event_flag", line_err, 1);
        chk("clr_vs_event_cnt", err_cnt, CNT_EN ? 1 : 0);
        idle(3);
        chk("wait_de_after_flush", {busy, vif.fifo_rst}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/line_win_ctrl.md
Name: line_win_ctrl

Overview:
- Sequencing controller for the 1-bit 3x3 window generator (two cascaded line-buffer FIFOs plus a 3x3 shift register).
- Derives frame/line position from video_vs/video_de.
- Flushes the line FIFOs at every frame start.
- Generates the FIFO write/read enables.
- Produces a window-valid strobe with border-validity flags for downstream morphology filters.
- Detects and flags malformed frames: short lines, truncated frames, and de during flush.

Parameters:
- IMG_WIDTH, 1920: active pixels per line.
- IMG_HEIGHT, 1080: active lines per frame.
- FLUSH_CYCLES, 4: fifo_rst pulse length in cycles; must be >= 1.
- CNT_W, 12: width of the x/y counters; must satisfy 2^CNT_W > max(IMG_WIDTH, IMG_HEIGHT).

Ports:
- video_clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- video_vs  in  1  frame sync, active-high; its rising edge marks frame start.
- video_de  in  1  pixel valid.
- err_clr  in  1  synchronous clear of line_err/err_cnt.
- fifo_rst  out  1  active-high reset to both line FIFOs.
- wr1_en  out  1  line FIFO 1 write enable.
- wr2_en  out  1  line FIFO 2 write enable.
- rd_en  out  1  read enable for both FIFOs.
- win_de  out  1  3x3 window valid.
- win_row_inv  out  1  window rows 1..2 not yet filled; aligned with win_de.
- win_col_inv  out  1  window columns 1..2 not yet filled; aligned with win_de.
- x_cnt  out  CNT_W  current column.
- y_cnt  out  CNT_W  current row.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.
- busy  out  1  state != IDLE.
- line_err  out  1  sticky error flag.
- err_cnt  out  8  saturating error count.

Behaviour:
- Reset: state IDLE; all outputs 0; internal delay registers 0.
- vs edge: vs_rise = video_vs & ~vs_d, where vs_d is video_vs registered once.
- States:
  - IDLE: vs_rise -> FLUSH.
  - FLUSH: fifo_rst=1 for exactly FLUSH_CYCLES cycles; x_cnt/y_cnt held at 0; then -> WAIT_DE.
  - WAIT_DE: first video_de=1 -> ACTIVE. That pixel is counted as x=0, y=0.
  - ACTIVE: frame pixels counted as below.
- vs_rise in any state (including FLUSH) -> FLUSH, counters cleared, flush counter restarts. If the state was ACTIVE, this counts as a truncated frame: error event.
- Counting in WAIT_DE/ACTIVE, on each de=1 cycle:
  - If x_cnt==IMG_WIDTH-1: x_cnt<=0 and y_cnt<=y_cnt+1.
  - Otherwise: x_cnt<=x_cnt+1.
  - de=1 with x_cnt==IMG_WIDTH-1 and y_cnt==IMG_HEIGHT-1: counters -> 0, state -> IDLE, frame_done=1 on the next cycle.
- Short line: de falling (de=0, de_d=1) with x_cnt!=0 -> error event, x_cnt<=0, y_cnt<=y_cnt+1. This keeps the FIFO line phase consistent.
- de=1 during FLUSH or IDLE: ignored for counting and enables. In FLUSH it is an error event.
- Enables (combinational from current de and counters; state in {WAIT_DE, ACTIVE}):
  - wr1_en = de & (y_cnt < IMG_HEIGHT-1).
  - rd_en = de & (y_cnt > 0).
  - wr2_en = wr1_en registered one cycle, which matches the one-cycle FIFO read latency.
- Window outputs:
  - win_de = enabled de delayed 2 cycles.
  - x_d2/y_d2 = counter values sampled with that de, delayed 2 cycles.
  - win_col_inv = x_d2 < 2; win_row_inv = y_d2 < 2.
  - Both flags are 0 when win_de=0.
  - Total latency from input pixel to win_de: 2 cycles.
- Errors:
  - Any error event sets line_err; it holds until err_clr or reset.
  - err_clr and an error event in the same cycle -> line_err=1 (set wins).
  - frame_done and vs_rise in the same cycle: frame_done still pulses, and the next frame proceeds normally.

Optional Feature:
- Macro: LINE_WIN_ERR_CNT_EN.
- Defined: err_cnt increments on each error event and saturates at 255. err_clr zeroes it; an event coinciding with err_clr gives 1.
- Undefined: err_cnt is tied to 0 and no counter is synthesised.

Decomposition:
- Package line_win_pkg:
  - state enum {IDLE, FLUSH, WAIT_DE, ACTIVE};
  - ERR_CNT_W=8 and ERR_CNT_MAX=255.
- Sub-module sig_delay (parameterised width/depth register pipe) for the de/x/y 2-cycle alignment.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=4, FLUSH_CYCLES=4):
1. Reset mid-ACTIVE frame -> all outputs 0 next cycle; next vs_rise restarts cleanly.
2. vs_rise then 4 full lines of 8 de pixels:
   - fifo_rst high for exactly 4 cycles;
   - wr1_en count 24, rd_en count 24, wr2_en = wr1_en delayed 1;
   - 32 win_de pulses at +2 cycles;
   - frame_done pulse 1 cycle after the 32nd pixel.
3. Border flags:
   - win_row_inv=1 for the first 16 win_de pulses, 0 after;
   - win_col_inv=1 for pixels x=0,1 of every line.
4. Line 1 with only 5 pixels -> line_err=1, y_cnt=2 after the de fall, err_cnt=1 (macro on) or 0 (macro off).
5. vs_rise when y_cnt=2 in ACTIVE -> error event, FLUSH entered, counters 0; de during FLUSH -> second error, err_cnt=2.
6. err_clr asserted together with an error event -> line_err stays 1, err_cnt=1.
